// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared definitions for the data-memory load/store controller:
// RV32I load/store funct3 encodings and the controller state type.
package dmem_lsu_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_ctrl_align.sv
// Combinational data path for the load/store controller: legality and
// alignment checks, store byte-lane replication and strobes, and load
// byte/halfword extraction with sign or zero extension.
module lsu_data_align
    import dmem_lsu_ctrl_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_low,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_aligned,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    // Decode the access width, flag bad encodings/alignment, and build lane data.
    always_comb begin
        illegal       = 1'b0;
        misaligned    = 1'b0;
        wstrb         = 4'b0000;
        wdata_aligned = wdata;
        rdata_ext     = 32'h0;
        shifted       = rdata >> {addr_low, 3'b000};
        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    wstrb         = 4'b0001 << addr_low;
                    wdata_aligned = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    wstrb         = 4'b0011 << {addr_low[1], 1'b0};
                    wdata_aligned = {2{wdata[15:0]}};
                    misaligned    = addr_low[0];
                end
                F3_SW: begin
                    wstrb      = 4'b1111;
                    misaligned = |addr_low;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
                F3_LBU: rdata_ext = {24'h0, shifted[7:0]};
                F3_LH: begin
                    rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
                    misaligned = addr_low[0];
                end
                F3_LHU: begin
                    rdata_ext  = {16'h0, shifted[15:0]};
                    misaligned = addr_low[0];
                end
                F3_LW: begin
                    rdata_ext  = shifted;
                    misaligned = |addr_low;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store initiator between the pipeline memory stage and the dmem
// request/ready port. One op at a time: accept, hold the request until the
// memory answers (or the timeout fires), then pulse a one-cycle response.
module dmem_lsu_ctrl
    import dmem_lsu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    input  logic                    req_is_store_i,
    input  logic [2:0]              req_funct3_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    req_ready_o,
    output logic                    resp_valid_o,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    output logic                    busy_o,
    output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
    output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] dmem_wstrb_o,
    output logic                    dmem_write_o,
    output logic                    dmem_read_o,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
    input  logic                    dmem_ready_i
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("dmem_lsu_ctrl: only DATA_WIDTH=32 is supported");
    end

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state;
    logic [CNT_W-1:0] count;
    logic [1:0]       addr_low_q;
    logic [2:0]       funct3_q;
    logic             is_store_q;

    logic             op_is_store;
    logic [2:0]       op_funct3;
    logic [1:0]       op_addr_low;
    logic             illegal;
    logic             misaligned;
    logic [3:0]       wstrb;
    logic [31:0]      wdata_aligned;
    logic [31:0]      rdata_ext;

    // In IDLE the checker looks at the incoming request; afterwards at the latched op.
    always_comb begin
        op_is_store = is_store_q;
        op_funct3   = funct3_q;
        op_addr_low = addr_low_q;
        if (state == IDLE) begin
            op_is_store = req_is_store_i;
            op_funct3   = req_funct3_i;
            op_addr_low = req_addr_i[1:0];
        end
    end

    lsu_data_align u_align (
        .is_store      (op_is_store),
        .funct3        (op_funct3),
        .addr_low      (op_addr_low),
        .wdata         (req_wdata_i),
        .rdata         (dmem_rdata_i),
        .illegal       (illegal),
        .misaligned    (misaligned),
        .wstrb         (wstrb),
        .wdata_aligned (wdata_aligned),
        .rdata_ext     (rdata_ext)
    );

    assign req_ready_o = (state == IDLE) && !rst;
    assign busy_o      = (state != IDLE);

    // Controller FSM with registered dmem request and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            addr_low_q   <= 2'b00;
            funct3_q     <= 3'b000;
            is_store_q   <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_wstrb_o <= '0;
            dmem_write_o <= 1'b0;
            dmem_read_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_low_q <= req_addr_i[1:0];
                        funct3_q   <= req_funct3_i;
                        is_store_q <= req_is_store_i;
                        count      <= '0;
                        if (illegal || misaligned) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else begin
                            state        <= ACCESS;
                            dmem_addr_o  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            dmem_wdata_o <= wdata_aligned;
                            dmem_wstrb_o <= req_is_store_i ? wstrb : 4'b0000;
                            dmem_write_o <= req_is_store_i;
                            dmem_read_o  <= !req_is_store_i;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ready_i) begin
                        state        <= RESP;
                        dmem_write_o <= 1'b0;
                        dmem_read_o  <= 1'b0;
                        dmem_wstrb_o <= '0;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= is_store_q ? 32'h0 : rdata_ext;
                    end else if ((TIMEOUT_CYCLES != 0) && (count == CNT_LAST)) begin
                        state        <= RESP;
                        dmem_write_o <= 1'b0;
                        dmem_read_o  <= 1'b0;
                        dmem_wstrb_o <= '0;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a small latency-programmable memory
// model and a response scoreboard.
module tb_dmem_lsu_ctrl;
    import dmem_lsu_ctrl_pkg::*;

    localparam int MEM_LAT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_is_store_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'b000;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        busy_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic        dmem_write_o;
    logic        dmem_read_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ready_i;

    dmem_lsu_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_is_store_i (req_is_store_i),
        .req_funct3_i   (req_funct3_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_ready_o    (req_ready_o),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .busy_o         (busy_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_wstrb_o   (dmem_wstrb_o),
        .dmem_write_o   (dmem_write_o),
        .dmem_read_o    (dmem_read_o),
        .dmem_rdata_i   (dmem_rdata_i),
        .dmem_ready_i   (dmem_ready_i)
    );

    always #5 clk = ~clk;

    // Memory model: ready pulses in the MEM_LAT-th cycle of a held request.
    logic [31:0] mem [0:63];
    int          lat_cnt = 0;
    logic        mem_on = 1'b1;
    logic        inject_ready = 1'b0;
    logic        model_ready;

    assign model_ready  = (dmem_read_o || dmem_write_o) && mem_on && (lat_cnt == MEM_LAT - 1);
    assign dmem_ready_i = model_ready || inject_ready;
    assign dmem_rdata_i = mem[dmem_addr_o[7:2]];

    always @(posedge clk) begin
        if ((dmem_read_o || dmem_write_o) && !model_ready)
            lat_cnt <= lat_cnt + 1;
        else
            lat_cnt <= 0;
        if (model_ready && dmem_write_o) begin
            for (int b = 0; b < 4; b++)
                if (dmem_wstrb_o[b]) mem[dmem_addr_o[7:2]][8*b +: 8] <= dmem_wdata_o[8*b +: 8];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   resp_seen = 0;

    int          last_wr, last_rd, last_busy, last_resp;
    logic [3:0]  last_strb;
    logic [31:0] last_wdata, last_addr;
    logic        last_stable;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid_o) begin
            resp_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_resp", 32'(resp_valid_o), 32'h0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("resp_rdata", resp_rdata_o, e.rdata);
                checkOutput("resp_err", 32'(resp_err_o), 32'(e.err));
            end
        end
    end

    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] er, input logic ee);
        exp_t e;
        bit   got = 0;
        bit   first = 1;
        @(negedge clk);
        checkOutput("req_ready", 32'(req_ready_o), 32'h1);
        req_valid_i    = 1'b1;
        req_is_store_i = st;
        req_funct3_i   = f3;
        req_addr_i     = a;
        req_wdata_i    = d;
        e.rdata = er;
        e.err   = ee;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid_i = 1'b0;
        last_wr = 0; last_rd = 0; last_busy = 0; last_resp = -1;
        last_strb = 4'h0; last_wdata = 32'h0; last_addr = 32'h0; last_stable = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (i > 0) @(negedge clk);
            if (busy_o) last_busy++;
            if (dmem_write_o) last_wr++;
            if (dmem_read_o) last_rd++;
            if (dmem_write_o || dmem_read_o) begin
                if (first) begin
                    first = 0;
                    last_strb = dmem_wstrb_o;
                    last_wdata = dmem_wdata_o;
                    last_addr = dmem_addr_o;
                end else if (last_strb !== dmem_wstrb_o || last_wdata !== dmem_wdata_o ||
                             last_addr !== dmem_addr_o) begin
                    last_stable = 1'b0;
                end
            end
            if (resp_valid_o) begin
                got = 1;
                last_resp = i;
            end
        end
        if (!got) checkOutput("resp_wait", 32'(resp_valid_o), 32'h1);
        @(negedge clk);
        checkOutput("busy_after_resp", 32'(busy_o), 32'h0);
        checkOutput("resp_one_cycle", 32'(resp_valid_o), 32'h0);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen_before;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("ready_during_rst", 32'(req_ready_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready_o), 32'h1);
        checkOutput("rst_busy", 32'(busy_o), 32'h0);
        checkOutput("rst_resp", {resp_rdata_o[30:0], resp_valid_o}, 32'h0);
        checkOutput("rst_dmem_ctl", {25'h0, resp_err_o, dmem_wstrb_o, dmem_write_o, dmem_read_o}, 32'h0);
        checkOutput("rst_dmem_addr", dmem_addr_o, 32'h0);
        checkOutput("rst_dmem_wdata", dmem_wdata_o, 32'h0);

        // SW 0x40 with five-cycle memory latency
        applyStimulus(1'b1, F3_SW, 32'h40, 32'hdeadbeef, 32'h0, 1'b0);
        checkOutput("sw_write_cycles", 32'(last_wr), 32'd5);
        checkOutput("sw_read_cycles", 32'(last_rd), 32'd0);
        checkOutput("sw_wstrb", 32'(last_strb), 32'hF);
        checkOutput("sw_wdata", last_wdata, 32'hdeadbeef);
        checkOutput("sw_stable", 32'(last_stable), 32'h1);
        checkOutput("sw_resp_lat", 32'(last_resp), 32'd5);
        checkOutput("sw_busy_cycles", 32'(last_busy), 32'd6);
        applyStimulus(1'b0, F3_LW, 32'h40, 32'h0, 32'hdeadbeef, 1'b0);
        checkOutput("lw_read_cycles", 32'(last_rd), 32'd5);
        checkOutput("lw_wstrb", 32'(last_strb), 32'h0);

        // SB 0x43 then byte loads
        applyStimulus(1'b1, F3_SB, 32'h43, 32'h000000A5, 32'h0, 1'b0);
        checkOutput("sb_wstrb", 32'(last_strb), 32'h8);
        checkOutput("sb_wdata", last_wdata, 32'hA5A5A5A5);
        checkOutput("sb_addr", last_addr, 32'h40);
        applyStimulus(1'b0, F3_LB, 32'h43, 32'h0, 32'hFFFFFFA5, 1'b0);
        applyStimulus(1'b0, F3_LBU, 32'h43, 32'h0, 32'h000000A5, 1'b0);

        // Halfword loads on 0x8001_1234
        applyStimulus(1'b1, F3_SW, 32'h40, 32'h80011234, 32'h0, 1'b0);
        applyStimulus(1'b0, F3_LH, 32'h42, 32'h0, 32'hFFFF8001, 1'b0);
        applyStimulus(1'b0, F3_LHU, 32'h42, 32'h0, 32'h00008001, 1'b0);
        applyStimulus(1'b0, F3_LH, 32'h40, 32'h0, 32'h00001234, 1'b0);
        applyStimulus(1'b0, F3_LB, 32'h41, 32'h0, 32'h00000012, 1'b0);
        applyStimulus(1'b0, F3_LH, 32'h41, 32'h0, 32'h0, 1'b1);
        checkOutput("lh_mis_read_cycles", 32'(last_rd), 32'd0);
        checkOutput("lh_mis_resp_lat", 32'(last_resp), 32'd0);
        applyStimulus(1'b0, F3_LW, 32'h42, 32'h0, 32'h0, 1'b1);
        checkOutput("lw_mis_read_cycles", 32'(last_rd), 32'd0);

        // SH to upper half of word 0x44
        applyStimulus(1'b1, F3_SH, 32'h46, 32'h0000BEEF, 32'h0, 1'b0);
        checkOutput("sh_wstrb", 32'(last_strb), 32'hC);
        checkOutput("sh_wdata", last_wdata, 32'hBEEFBEEF);
        applyStimulus(1'b0, F3_LH, 32'h46, 32'h0, 32'hFFFFBEEF, 1'b0);
        applyStimulus(1'b0, F3_LW, 32'h44, 32'h0, 32'hBEEF0000, 1'b0);

        // Timeout with memory never ready, then a stale ready in IDLE
        mem_on = 1'b0;
        applyStimulus(1'b0, F3_LW, 32'h44, 32'h0, 32'h0, 1'b1);
        checkOutput("to_read_cycles", 32'(last_rd), 32'd8);
        checkOutput("to_resp_lat", 32'(last_resp), 32'd8);
        checkOutput("to_read_dropped", 32'(dmem_read_o), 32'h0);
        mem_on = 1'b1;
        seen_before = resp_seen;
        inject_ready = 1'b1;
        @(negedge clk);
        inject_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stale_ready_resp", 32'(resp_seen - seen_before), 32'd0);
        checkOutput("stale_ready_busy", 32'(busy_o), 32'h0);

        // Reset in the second ACCESS cycle
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_is_store_i = 1'b0;
        req_funct3_i   = F3_LW;
        req_addr_i     = 32'h40;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_read_before", 32'(dmem_read_o), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_read_after", 32'(dmem_read_o), 32'h0);
        checkOutput("mid_rst_busy_after", 32'(busy_o), 32'h0);
        rst = 1'b0;
        seen_before = resp_seen;
        @(negedge clk);
        inject_ready = 1'b1;
        @(negedge clk);
        inject_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_rst_late_ready", 32'(resp_seen - seen_before), 32'd0);
        applyStimulus(1'b0, F3_LW, 32'h40, 32'h0, 32'h80011234, 1'b0);

        // Illegal funct3 encodings
        applyStimulus(1'b1, 3'd3, 32'h40, 32'h12345678, 32'h0, 1'b1);
        checkOutput("ill_st_busy", 32'(last_busy), 32'd1);
        checkOutput("ill_st_write", 32'(last_wr), 32'd0);
        applyStimulus(1'b0, 3'd7, 32'h40, 32'h0, 32'h0, 1'b1);
        checkOutput("ill_ld_busy", 32'(last_busy), 32'd1);
        checkOutput("ill_ld_read", 32'(last_rd), 32'd0);
        applyStimulus(1'b1, 3'd5, 32'h40, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, F3_LW, 32'h40, 32'h0, 32'h80011234, 1'b0);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
